ram_result_scanner: RTL and testbench

RAM_RESULT_SCANNER -- requirements
Module: ram_result_scanner

---
 rtl/scanner_pkg.sv | 12 +
 rtl/scan_accumulator.sv | 101 ++++++++++
 rtl/ram_result_scanner.sv | 94 +++++++++
 tb/tb_ram_result_scanner.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared FSM state type and default geometry for the RAM result scanner.
package scanner_pkg;
  localparam int unsigned SCAN_ADDR_W = 9;
  localparam int unsigned SCAN_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_DONE
  } scan_state_e;
endpackage

// File: rtl/scan_accumulator.sv
// Per-word accumulate/compare datapath: RAM0 sum and unsigned max, RAM1 signed max and negative count.
// Optional min tracking is compiled in with SCANNER_MIN_TRACK_EN.
module scan_accumulator
  import scanner_pkg::*;
#(
  parameter int unsigned ADDR_W = SCAN_ADDR_W,
  parameter int unsigned DATA_W = SCAN_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     valid_i,
  input  logic [DATA_W-1:0]        data0_i,
  input  logic [DATA_W-1:0]        data1_i,
  output logic [ADDR_W+DATA_W-1:0] sum0_o,
  output logic [DATA_W-1:0]        max0_o,
  output logic [DATA_W-1:0]        max1_o,
`ifdef SCANNER_MIN_TRACK_EN
  output logic [DATA_W-1:0]        min0_o,
  output logic [DATA_W-1:0]        min1_o,
`endif
  output logic [ADDR_W:0]          neg_count_o
);
  localparam int unsigned SUM_W = ADDR_W + DATA_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [SUM_W-1:0]  sum0_q, sum0_d;
  logic [DATA_W-1:0] max0_q, max0_d;
  logic [DATA_W-1:0] max1_q, max1_d;
  logic [CNT_W-1:0]  neg_q,  neg_d;

  always_comb begin
    sum0_d = sum0_q;
    max0_d = max0_q;
    max1_d = max1_q;
    neg_d  = neg_q;
    if (clr_i) begin
      sum0_d = '0;
      max0_d = '0;
      max1_d = MOST_NEG;
      neg_d  = '0;
    end else if (valid_i) begin
      sum0_d = sum0_q + SUM_W'(data0_i);
      if (data0_i > max0_q) max0_d = data0_i;
      if ($signed(data1_i) > $signed(max1_q)) max1_d = data1_i;
      neg_d = neg_q + CNT_W'(data1_i[DATA_W-1]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum0_q <= '0;
      max0_q <= '0;
      max1_q <= '0;
      neg_q  <= '0;
    end else begin
      sum0_q <= sum0_d;
      max0_q <= max0_d;
      max1_q <= max1_d;
      neg_q  <= neg_d;
    end
  end

  assign sum0_o      = sum0_q;
  assign max0_o      = max0_q;
  assign max1_o      = max1_q;
  assign neg_count_o = neg_q;

`ifdef SCANNER_MIN_TRACK_EN
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] min0_q, min0_d;
  logic [DATA_W-1:0] min1_q, min1_d;

  always_comb begin
    min0_d = min0_q;
    min1_d = min1_q;
    if (clr_i) begin
      min0_d = '1;
      min1_d = MOST_POS;
    end else if (valid_i) begin
      if (data0_i < min0_q) min0_d = data0_i;
      if ($signed(data1_i) < $signed(min1_q)) min1_d = data1_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      min0_q <= '0;
      min1_q <= '0;
    end else begin
      min0_q <= min0_d;
      min1_q <= min1_d;
    end
  end

  assign min0_o = min0_q;
  assign min1_o = min1_q;
`endif
endmodule

// File: rtl/ram_result_scanner.sv
// Scans two registered-address result RAMs once per accepted start and reports sum/max/negative count.
// Define SCANNER_MIN_TRACK_EN to add min0_o/min1_o.
module ram_result_scanner
  import scanner_pkg::*;
#(
  parameter int unsigned ADDR_W = SCAN_ADDR_W,
  parameter int unsigned DATA_W = SCAN_DATA_W
) (
  input  logic                     CLOCK_50_I,
  input  logic                     RESET_I,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDR_W-1:0]        rd_address_o,
  input  logic [DATA_W-1:0]        rd_data0_i,
  input  logic [DATA_W-1:0]        rd_data1_i,
  output logic [ADDR_W+DATA_W-1:0] sum0_o,
  output logic [DATA_W-1:0]        max0_o,
  output logic [DATA_W-1:0]        max1_o,
`ifdef SCANNER_MIN_TRACK_EN
  output logic [DATA_W-1:0]        min0_o,
  output logic [DATA_W-1:0]        min1_o,
`endif
  output logic [ADDR_W:0]          neg_count_o
);
  scan_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_valid_q;
  logic              start_acc;

  assign start_acc = (state_q == S_IDLE) && start_i;

  // rd_valid_q lags the issued address by one cycle, matching the RAM's registered read.
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= (state_q == S_READ);
      unique case (state_q)
        S_IDLE: begin
          addr_q <= '0;
          if (start_i) begin
            state_q <= S_READ;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          addr_q <= addr_q + ADDR_W'(1);
          if (addr_q == '1) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign rd_address_o = addr_q;

  scan_accumulator #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_acc (
    .clk_i      (CLOCK_50_I),
    .rst_i      (RESET_I),
    .clr_i      (start_acc),
    .valid_i    (rd_valid_q),
    .data0_i    (rd_data0_i),
    .data1_i    (rd_data1_i),
    .sum0_o     (sum0_o),
    .max0_o     (max0_o),
    .max1_o     (max1_o),
`ifdef SCANNER_MIN_TRACK_EN
    .min0_o     (min0_o),
    .min1_o     (min1_o),
`endif
    .neg_count_o(neg_count_o)
  );
endmodule

// File: tb/tb_ram_result_scanner.sv
// Self-checking bench for ram_result_scanner against a whole-array reference model.
module tb_ram_result_scanner;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned SW    = AW + DW;
`ifdef SCANNER_MIN_TRACK_EN
  localparam int unsigned RW = SW + 2*DW + AW + 1 + 2*DW;
`else
  localparam int unsigned RW = SW + 2*DW + AW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy_o, done_o;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] rd_data0, rd_data1;
  logic [SW-1:0] sum0_o;
  logic [DW-1:0] max0_o, max1_o;
  logic [AW:0]   neg_count_o;
`ifdef SCANNER_MIN_TRACK_EN
  logic [DW-1:0] min0_o, min1_o;
`endif

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [RW-1:0] exp_res, dut_res;
  int checks = 0;
  int errors = 0;

  ram_result_scanner #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLOCK_50_I  (clk),
    .RESET_I     (rst),
    .start_i     (start),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_address_o(rd_address),
    .rd_data0_i  (rd_data0),
    .rd_data1_i  (rd_data1),
    .sum0_o      (sum0_o),
    .max0_o      (max0_o),
    .max1_o      (max1_o),
`ifdef SCANNER_MIN_TRACK_EN
    .min0_o      (min0_o),
    .min1_o      (min1_o),
`endif
    .neg_count_o (neg_count_o)
  );

`ifdef SCANNER_MIN_TRACK_EN
  assign dut_res = {sum0_o, max0_o, max1_o, neg_count_o, min0_o, min1_o};
`else
  assign dut_res = {sum0_o, max0_o, max1_o, neg_count_o};
`endif

  always #5 clk = ~clk;

  // Registered-address RAM: data for an address appears one cycle later.
  always @(posedge clk) begin
    rd_data0 <= mem0[rd_address];
    rd_data1 <= mem1[rd_address];
  end

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model();
    longint s = 0;
    int mx0 = 0, mx1 = -(1 << (DW-1)), neg = 0;
    int mn0 = (1 << DW) - 1, mn1 = (1 << (DW-1)) - 1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      int u0 = int'(mem0[k]);
      int v1 = int'(mem1[k]) - (mem1[k][DW-1] ? (1 << DW) : 0);
      s += u0;
      if (u0 > mx0) mx0 = u0;
      if (u0 < mn0) mn0 = u0;
      if (v1 > mx1) mx1 = v1;
      if (v1 < mn1) mn1 = v1;
      if (v1 < 0) neg++;
    end
`ifdef SCANNER_MIN_TRACK_EN
    exp_res = {SW'(s), DW'(mx0), DW'(mx1), (AW+1)'(neg), DW'(mn0), DW'(mn1)};
`else
    exp_res = {SW'(s), DW'(mx0), DW'(mx1), (AW+1)'(neg)};
`endif
  endtask

  // Pulses start for one edge, then watches 600 cycles; optional extra start pulses at cycles pa/pb.
  task automatic run_scan(input int pa, input int pb, output int done_cyc, output int n_done,
                          output logic busy_early, output logic busy_end);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_cyc = -1;
    n_done = 0;
    busy_early = 1'b0;
    busy_end = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      start = (n == pa) || (n == pb);
      if (n == 1) busy_early = busy_o;
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
    end
    busy_end = busy_o;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dut_res !== '0) begin errors++; $display("FAIL reset_results: got %0h want 0", dut_res); end
    checks++; if ({busy_o, done_o} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {busy_o, done_o}); end
    checks++; if (rd_address !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", rd_address); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_const();
    int dc, nd; logic be, bn;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = 8'hFF; mem1[k] = 8'h00; end
    model();
    run_scan(0, 0, dc, nd, be, bn);
    checks++; if (dc !== 514) begin errors++; $display("FAIL const_done_cycle: got %0d want 514", dc); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL const_done_count: got %0d want 1", nd); end
    checks++; if ({be, bn} !== 2'b10) begin errors++; $display("FAIL const_busy: got %b want 10", {be, bn}); end
    checks++; if (sum0_o !== 17'h1FE00) begin errors++; $display("FAIL const_sum0: got %0h want 1fe00", sum0_o); end
    checks++; if ({max0_o, max1_o, neg_count_o} !== {8'hFF, 8'h00, 10'd0}) begin
      errors++; $display("FAIL const_max_neg: got %0h/%0h/%0d want ff/0/0", max0_o, max1_o, neg_count_o); end
    checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL const_model: got %0h want %0h", dut_res, exp_res); end
  endtask

  task automatic test_ramp();
    int dc, nd; logic be, bn;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'(k % 256); mem1[k] = DW'(k % 256); end
    model();
    run_scan(0, 0, dc, nd, be, bn);
    checks++; if (sum0_o !== SW'(65280)) begin errors++; $display("FAIL ramp_sum0: got %0d want 65280", sum0_o); end
    checks++; if ({max0_o, max1_o} !== {8'hFF, 8'h7F}) begin errors++; $display("FAIL ramp_max: got %0h/%0h want ff/7f", max0_o, max1_o); end
    checks++; if (neg_count_o !== 10'd256) begin errors++; $display("FAIL ramp_neg: got %0d want 256", neg_count_o); end
    checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL ramp_model: got %0h want %0h", dut_res, exp_res); end
  endtask

  task automatic test_all_neg();
    int dc, nd; logic be, bn;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'($urandom); mem1[k] = 8'h80; end
    model();
    run_scan(0, 0, dc, nd, be, bn);
    checks++; if (max1_o !== 8'h80) begin errors++; $display("FAIL neg_max1: got %0h want 80", max1_o); end
    checks++; if (neg_count_o !== 10'd512) begin errors++; $display("FAIL neg_count: got %0d want 512", neg_count_o); end
`ifdef SCANNER_MIN_TRACK_EN
    checks++; if (min1_o !== 8'h80) begin errors++; $display("FAIL neg_min1: got %0h want 80", min1_o); end
`endif
    checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL neg_model: got %0h want %0h", dut_res, exp_res); end
  endtask

  task automatic test_random();
    int dc, nd; logic be, bn;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'($urandom); mem1[k] = DW'($urandom); end
      model();
      run_scan(0, 0, dc, nd, be, bn);
      checks++; if (dc !== 514) begin errors++; $display("FAIL random%0d_done_cycle: got %0d want 514", r, dc); end
      checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL random%0d_model: got %0h want %0h", r, dut_res, exp_res); end
    end
  endtask

  task automatic test_ignore_start();
    int dc, nd; logic be, bn;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'($urandom); mem1[k] = DW'($urandom); end
    model();
    run_scan(100, 300, dc, nd, be, bn);
    checks++; if (nd !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", nd); end
    checks++; if (dc !== 514) begin errors++; $display("FAIL ignore_done_cycle: got %0d want 514", dc); end
    checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL ignore_model: got %0h want %0h", dut_res, exp_res); end
  endtask

  task automatic test_reset_mid();
    int dc, nd, seen; logic be, bn;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'($urandom); mem1[k] = DW'($urandom); end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (dut_res !== '0) begin errors++; $display("FAIL abort_results: got %0h want 0", dut_res); end
    checks++; if ({busy_o, done_o, rd_address} !== '0) begin
      errors++; $display("FAIL abort_ctrl: got %b/%b/%0h want 0/0/0", busy_o, done_o, rd_address); end
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
    model();
    run_scan(0, 0, dc, nd, be, bn);
    checks++; if (dc !== 514) begin errors++; $display("FAIL abort_rescan_cycle: got %0d want 514", dc); end
    checks++; if (dut_res !== exp_res) begin errors++; $display("FAIL abort_rescan_model: got %0h want %0h", dut_res, exp_res); end
  endtask

  task automatic test_back_to_back();
    int d [8];
    int cnt = 0, bad = 0;
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = DW'($urandom); mem1[k] = DW'($urandom); end
    model();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 3*515 + 10; n++) begin
      @(negedge clk);
      if (done_o) begin
        if (cnt < 8) d[cnt] = n;
        if (dut_res !== exp_res) bad++;
        cnt++;
      end
    end
    start = 1'b0;
    repeat (600) @(negedge clk);
    checks++; if (cnt !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", cnt); end
    checks++; if (d[0] !== 514) begin errors++; $display("FAIL b2b_first: got %0d want 514", d[0]); end
    checks++; if ({d[1] - d[0], d[2] - d[1]} !== {32'd515, 32'd515}) begin
      errors++; $display("FAIL b2b_period: got %0d,%0d want 515,515", d[1] - d[0], d[2] - d[1]); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_results: got %0d bad scans want 0", bad); end
  endtask

  initial begin
    for (int k = 0; k < int'(DEPTH); k++) begin mem0[k] = '0; mem1[k] = '0; end
    test_reset();
    test_const();
    test_ramp();
    test_all_neg();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
